// File: rtl/cdb_arbiter.sv
// Common-data-bus arbiter: buffers results from N_FU functional units in
// small per-unit FIFOs and broadcasts one result per cycle, picked round-robin.
module cdb_arbiter #(
  parameter int BITWIDTH   = 32,
  parameter int N_FU       = 4,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       en,
  input  logic                       flush,
  input  logic [N_FU-1:0]            fu_valid,
  output logic [N_FU-1:0]            fu_ready,
  input  logic [N_FU*BITWIDTH-1:0]   fu_tag,
  input  logic [N_FU*BITWIDTH-1:0]   fu_data,
  output logic                       cdb_valid,
  output logic [BITWIDTH-1:0]        cdb_tag,
  output logic [BITWIDTH-1:0]        cdb_data,
  output logic [$clog2(N_FU)-1:0]    cdb_src,
  output logic                       busy
);

  localparam int SRC_W = $clog2(N_FU);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [BITWIDTH-1:0] r_memTag  [N_FU][FIFO_DEPTH];
  logic [BITWIDTH-1:0] r_memData [N_FU][FIFO_DEPTH];
  logic [PTR_W-1:0]    r_wrPtr   [N_FU];
  logic [PTR_W-1:0]    r_rdPtr   [N_FU];
  logic [CNT_W-1:0]    r_count   [N_FU];

  logic [SRC_W-1:0]    r_rrPtr;
  logic                r_cdbValid;
  logic [BITWIDTH-1:0] r_cdbTag;
  logic [BITWIDTH-1:0] r_cdbData;
  logic [SRC_W-1:0]    r_cdbSrc;

  logic [N_FU-1:0]     w_full;
  logic [N_FU-1:0]     w_nonEmpty;
  logic [N_FU-1:0]     w_ready;
  logic [N_FU-1:0]     w_push;
  logic [N_FU-1:0]     w_pop;
  logic                w_arbEn;
  logic                w_grantValid;
  logic [SRC_W-1:0]    w_grantIdx;
  logic [SRC_W-1:0]    w_rrNext;
  logic                w_hiFound;
  logic [SRC_W-1:0]    w_hiIdx;
  logic [SRC_W-1:0]    w_loIdx;

  // Per-FIFO full/empty flags decoded from the registered counts only.
  always_comb begin
    w_full     = '0;
    w_nonEmpty = '0;
    for (int i = 0; i < N_FU; i++) begin
      w_full[i]     = (r_count[i] == CNT_W'(FIFO_DEPTH));
      w_nonEmpty[i] = (r_count[i] != '0);
    end
  end

  // Ready never looks at fu_valid, and is held low while reset is asserted.
  assign w_arbEn  = en & ~flush;
  assign w_ready  = {N_FU{rst_n & w_arbEn}} & ~w_full;
  assign w_push   = fu_valid & w_ready;
  assign fu_ready = w_ready;

  // Round-robin pick: lowest non-empty index at or above rr_ptr, else lowest overall.
  always_comb begin
    w_hiFound = 1'b0;
    w_hiIdx   = '0;
    w_loIdx   = '0;
    for (int i = N_FU - 1; i >= 0; i--) begin
      if (w_nonEmpty[i]) begin
        if (i >= int'(r_rrPtr)) begin
          w_hiFound = 1'b1;
          w_hiIdx   = SRC_W'(i);
        end
        w_loIdx = SRC_W'(i);
      end
    end
    w_grantValid = |w_nonEmpty;
    w_grantIdx   = w_hiFound ? w_hiIdx : w_loIdx;
  end

  assign w_rrNext = (w_grantIdx == SRC_W'(N_FU - 1)) ? '0 : w_grantIdx + SRC_W'(1);
  assign w_pop    = (w_grantValid && w_arbEn) ? (N_FU'(1) << w_grantIdx) : '0;

  // FIFO pointers and occupancy; flush empties everything, simultaneous push+pop keeps count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_FU; i++) begin
        r_wrPtr[i] <= '0;
        r_rdPtr[i] <= '0;
        r_count[i] <= '0;
      end
    end else if (flush) begin
      for (int i = 0; i < N_FU; i++) begin
        r_wrPtr[i] <= '0;
        r_rdPtr[i] <= '0;
        r_count[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N_FU; i++) begin
        if (w_push[i]) begin
          r_wrPtr[i] <= r_wrPtr[i] + PTR_W'(1);
        end
        if (w_pop[i]) begin
          r_rdPtr[i] <= r_rdPtr[i] + PTR_W'(1);
        end
        if (w_push[i] && !w_pop[i]) begin
          r_count[i] <= r_count[i] + CNT_W'(1);
        end else if (!w_push[i] && w_pop[i]) begin
          r_count[i] <= r_count[i] - CNT_W'(1);
        end
      end
    end
  end

  // FIFO payload storage; contents are meaningless until a count covers them.
  always_ff @(posedge clk) begin
    for (int i = 0; i < N_FU; i++) begin
      if (w_push[i]) begin
        r_memTag[i][r_wrPtr[i]]  <= fu_tag[i*BITWIDTH +: BITWIDTH];
        r_memData[i][r_wrPtr[i]] <= fu_data[i*BITWIDTH +: BITWIDTH];
      end
    end
  end

  // Broadcast register: one granted head per cycle, payload holds when idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cdbValid <= 1'b0;
      r_cdbTag   <= '0;
      r_cdbData  <= '0;
      r_cdbSrc   <= '0;
      r_rrPtr    <= '0;
    end else if (flush) begin
      r_cdbValid <= 1'b0;
      r_rrPtr    <= '0;
    end else if (en && w_grantValid) begin
      r_cdbValid <= 1'b1;
      r_cdbTag   <= r_memTag[w_grantIdx][r_rdPtr[w_grantIdx]];
      r_cdbData  <= r_memData[w_grantIdx][r_rdPtr[w_grantIdx]];
      r_cdbSrc   <= w_grantIdx;
      r_rrPtr    <= w_rrNext;
    end else begin
      r_cdbValid <= 1'b0;
    end
  end

  assign cdb_valid = r_cdbValid;
  assign cdb_tag   = r_cdbTag;
  assign cdb_data  = r_cdbData;
  assign cdb_src   = r_cdbSrc;
  assign busy      = (|w_nonEmpty) | r_cdbValid;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: hand-derived vector table, directed
// corner sequences, and a queue-based reference model with a broadcast scoreboard.
module tb_cdb_arbiter;

  localparam int BW    = 32;
  localparam int NFU   = 4;
  localparam int DEPTH = 2;
  localparam int NVEC  = 22;

  logic              clk;
  logic              rst_n;
  logic              en;
  logic              flush;
  logic [NFU-1:0]    fu_valid;
  logic [NFU-1:0]    fu_ready;
  logic [NFU*BW-1:0] fu_tag;
  logic [NFU*BW-1:0] fu_data;
  logic              cdb_valid;
  logic [BW-1:0]     cdb_tag;
  logic [BW-1:0]     cdb_data;
  logic [1:0]        cdb_src;
  logic              busy;

  typedef struct packed {
    logic [BW-1:0] tag;
    logic [BW-1:0] data;
    logic [1:0]    src;
  } bcast_t;

  typedef struct packed {
    logic       en;
    logic       flush;
    logic [3:0] valid;
    logic       expValid;
    logic [1:0] expSrc;
    logic [3:0] expReady;
    logic       expBusy;
  } vec_t;

  int nChecks = 0;
  int nErrors = 0;
  int stepCnt = 0;

  bcast_t        sbQ[$];
  logic [BW-1:0] mTag  [NFU][$];
  logic [BW-1:0] mData [NFU][$];
  int            mRr;
  logic          mValid;
  bcast_t        mLast;
  int            mGrant;
  logic [NFU-1:0] mRdy;

  vec_t vecs [NVEC];

  cdb_arbiter #(.BITWIDTH(BW), .N_FU(NFU), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .flush(flush),
    .fu_valid(fu_valid), .fu_ready(fu_ready), .fu_tag(fu_tag), .fu_data(fu_data),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .cdb_src(cdb_src), .busy(busy)
  );

  // Free-running clock, 10 time units per period.
  always #5 clk = ~clk;

  // Reference model: per-FU queues, grant chosen from pre-edge contents, expected broadcasts queued.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NFU; i++) begin
        mTag[i].delete();
        mData[i].delete();
      end
      sbQ.delete();
      mRr    = 0;
      mValid = 1'b0;
      mLast  = '0;
    end else begin
      mGrant = -1;
      if (en && !flush) begin
        for (int off = 0; off < NFU; off++) begin
          if (mGrant < 0 && mTag[(mRr + off) % NFU].size() > 0) mGrant = (mRr + off) % NFU;
        end
      end
      for (int i = 0; i < NFU; i++) mRdy[i] = en && !flush && (mTag[i].size() < DEPTH);
      if (flush) begin
        for (int i = 0; i < NFU; i++) begin
          mTag[i].delete();
          mData[i].delete();
        end
        mRr    = 0;
        mValid = 1'b0;
      end else begin
        if (mGrant >= 0) begin
          mLast.tag  = mTag[mGrant].pop_front();
          mLast.data = mData[mGrant].pop_front();
          mLast.src  = 2'(mGrant);
          sbQ.push_back(mLast);
          mRr    = (mGrant + 1) % NFU;
          mValid = 1'b1;
        end else begin
          mValid = 1'b0;
        end
        for (int i = 0; i < NFU; i++) begin
          if (fu_valid[i] && mRdy[i]) begin
            mTag[i].push_back(fu_tag[i*BW +: BW]);
            mData[i].push_back(fu_data[i*BW +: BW]);
          end
        end
      end
    end
  end

  task automatic checkVal(input string name, input logic [63:0] act, input logic [63:0] exp);
    nChecks++;
    if (act !== exp) begin
      nErrors++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic checkOutput();
    bcast_t         rec;
    logic [NFU-1:0] expRdy;
    logic           anyQ;
    checkVal("cdb_valid", 64'(cdb_valid), 64'(mValid));
    if (mValid) begin
      if (sbQ.size() == 0) begin
        nChecks++;
        nErrors++;
        $display("[TB] FAIL scoreboard_underflow: got broadcast, expected none queued");
      end else begin
        rec = sbQ.pop_front();
        checkVal("cdb_tag", 64'(cdb_tag), 64'(rec.tag));
        checkVal("cdb_data", 64'(cdb_data), 64'(rec.data));
        checkVal("cdb_src", 64'(cdb_src), 64'(rec.src));
      end
    end else begin
      checkVal("hold_tag", 64'(cdb_tag), 64'(mLast.tag));
      checkVal("hold_data", 64'(cdb_data), 64'(mLast.data));
      checkVal("hold_src", 64'(cdb_src), 64'(mLast.src));
    end
    anyQ = 1'b0;
    for (int i = 0; i < NFU; i++) begin
      expRdy[i] = rst_n && en && !flush && (mTag[i].size() < DEPTH);
      if (mTag[i].size() > 0) anyQ = 1'b1;
    end
    checkVal("fu_ready", 64'(fu_ready), 64'(expRdy));
    checkVal("busy", 64'(busy), 64'(anyQ | mValid));
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  task automatic applyStimulus(input logic e, input logic f, input logic [NFU-1:0] v);
    en       = e;
    flush    = f;
    fu_valid = v;
    stepCnt++;
    for (int i = 0; i < NFU; i++) begin
      fu_tag[i*BW +: BW]  = {16'(i + 1), 16'(stepCnt)};
      fu_data[i*BW +: BW] = $urandom;
    end
  endtask

  function automatic vec_t mkVec(input logic e, input logic f, input logic [3:0] v,
                                 input logic xv, input logic [1:0] xs,
                                 input logic [3:0] xr, input logic xb);
    vec_t r;
    r.en = e; r.flush = f; r.valid = v;
    r.expValid = xv; r.expSrc = xs; r.expReady = xr; r.expBusy = xb;
    return r;
  endfunction

  // Directed and randomised test sequence.
  initial begin
    int grants;
    int seen;
    int staleCnt;

    vecs[0]  = mkVec(1, 0, 4'b1111, 0, 0, 4'b1111, 1);
    vecs[1]  = mkVec(1, 0, 4'b0000, 1, 0, 4'b1111, 1);
    vecs[2]  = mkVec(1, 0, 4'b0000, 1, 1, 4'b1111, 1);
    vecs[3]  = mkVec(1, 0, 4'b0000, 1, 2, 4'b1111, 1);
    vecs[4]  = mkVec(1, 0, 4'b0000, 1, 3, 4'b1111, 1);
    vecs[5]  = mkVec(1, 0, 4'b0000, 0, 0, 4'b1111, 0);
    vecs[6]  = mkVec(1, 0, 4'b1111, 0, 0, 4'b1111, 1);
    vecs[7]  = mkVec(1, 0, 4'b1000, 1, 0, 4'b0111, 1);
    vecs[8]  = mkVec(1, 0, 4'b0000, 1, 1, 4'b0111, 1);
    vecs[9]  = mkVec(1, 0, 4'b0000, 1, 2, 4'b0111, 1);
    vecs[10] = mkVec(1, 0, 4'b0000, 1, 3, 4'b1111, 1);
    vecs[11] = mkVec(1, 0, 4'b0000, 1, 3, 4'b1111, 1);
    vecs[12] = mkVec(1, 0, 4'b0000, 0, 0, 4'b1111, 0);
    vecs[13] = mkVec(0, 0, 4'b0100, 0, 0, 4'b0000, 0);
    vecs[14] = mkVec(1, 0, 4'b0100, 0, 0, 4'b1111, 1);
    vecs[15] = mkVec(0, 0, 4'b0000, 0, 0, 4'b0000, 1);
    vecs[16] = mkVec(0, 0, 4'b0000, 0, 0, 4'b0000, 1);
    vecs[17] = mkVec(1, 0, 4'b0000, 1, 2, 4'b1111, 1);
    vecs[18] = mkVec(1, 0, 4'b0000, 0, 0, 4'b1111, 0);
    vecs[19] = mkVec(1, 0, 4'b0111, 0, 0, 4'b1111, 1);
    vecs[20] = mkVec(1, 1, 4'b0000, 0, 0, 4'b0000, 0);
    vecs[21] = mkVec(1, 0, 4'b0000, 0, 0, 4'b1111, 0);

    clk = 1'b0; rst_n = 1'b0; en = 1'b0; flush = 1'b0;
    fu_valid = '0; fu_tag = '0; fu_data = '0;

    repeat (3) cycle();
    checkVal("reset_cdb_tag", 64'(cdb_tag), 64'(0));
    checkVal("reset_cdb_data", 64'(cdb_data), 64'(0));
    checkVal("reset_cdb_src", 64'(cdb_src), 64'(0));
    en = 1'b1;
    #1;
    checkVal("reset_fu_ready", 64'(fu_ready), 64'(0));
    checkVal("reset_busy", 64'(busy), 64'(0));
    rst_n = 1'b1;

    for (int s = 0; s < NVEC; s++) begin
      applyStimulus(vecs[s].en, vecs[s].flush, vecs[s].valid);
      cycle();
      checkVal($sformatf("vec%0d_valid", s), 64'(cdb_valid), 64'(vecs[s].expValid));
      if (vecs[s].expValid) checkVal($sformatf("vec%0d_src", s), 64'(cdb_src), 64'(vecs[s].expSrc));
      checkVal($sformatf("vec%0d_ready", s), 64'(fu_ready), 64'(vecs[s].expReady));
      checkVal($sformatf("vec%0d_busy", s), 64'(busy), 64'(vecs[s].expBusy));
    end

    applyStimulus(1, 0, 4'b0100);
    fu_tag[2*BW +: BW]  = 32'h0001_0003;
    fu_data[2*BW +: BW] = 32'hDEAD_BEEF;
    cycle();
    checkVal("single_k_valid", 64'(cdb_valid), 64'(0));
    applyStimulus(1, 0, 4'b0000);
    cycle();
    checkVal("single_valid", 64'(cdb_valid), 64'(1));
    checkVal("single_tag", 64'(cdb_tag), 64'(32'h0001_0003));
    checkVal("single_data", 64'(cdb_data), 64'(32'hDEAD_BEEF));
    checkVal("single_src", 64'(cdb_src), 64'(2));
    cycle();
    checkVal("single_after_valid", 64'(cdb_valid), 64'(0));

    applyStimulus(1, 1, 4'b0000);
    cycle();
    applyStimulus(1, 0, 4'b0011);
    cycle();
    grants = 0;
    seen   = 0;
    for (int c = 0; c < 10 && seen == 0; c++) begin
      applyStimulus(1, 0, 4'b0001);
      cycle();
      if (cdb_valid === 1'b1) begin
        grants++;
        if (cdb_src === 2'd1) seen = 1;
      end
    end
    checkVal("fair_fu1_seen", 64'(seen), 64'(1));
    checkVal("fair_grants", 64'(grants), 64'(2));
    repeat (6) begin
      applyStimulus(1, 0, 4'b0001);
      cycle();
    end
    repeat (4) begin
      applyStimulus(1, 0, 4'b0000);
      cycle();
    end

    applyStimulus(1, 0, 4'b1111);
    cycle();
    applyStimulus(1, 0, 4'b0000);
    cycle();
    #3 rst_n = 1'b0;
    #1;
    checkVal("rstmid_valid", 64'(cdb_valid), 64'(0));
    checkVal("rstmid_ready", 64'(fu_ready), 64'(0));
    checkVal("rstmid_busy", 64'(busy), 64'(0));
    cycle();
    rst_n = 1'b1;
    staleCnt = 0;
    repeat (6) begin
      applyStimulus(1, 0, 4'b0000);
      cycle();
      if (cdb_valid !== 1'b0) staleCnt++;
    end
    checkVal("rstmid_no_stale", 64'(staleCnt), 64'(0));

    for (int c = 0; c < 300; c++) begin
      applyStimulus(($urandom_range(0, 7) != 0), ($urandom_range(0, 24) == 0), 4'($urandom));
      cycle();
    end
    repeat (12) begin
      applyStimulus(1, 0, 4'b0000);
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
    $finish;
  end

endmodule

// File: doc/cdb_arbiter.md
CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 The block SHALL take parameter BITWIDTH, default 32, as the width of tag and data words; tags follow the RS entry-ID format (upper half = RS ID, lower half = entry index).
REQ-002 The block SHALL take parameter N_FU, default 4, as the number of functional-unit result ports (2..8).
REQ-003 The block SHALL take parameter FIFO_DEPTH, default 2, as the per-FU result buffer depth (power of 2, at least 2).
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock, rising-edge active.
REQ-005 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-006 The block SHALL have port en, input, 1 bit: global enable.
REQ-007 The block SHALL have port flush, input, 1 bit: synchronous discard of all buffered results.
REQ-008 The block SHALL have port fu_valid, input, N_FU bits: per-FU result valid.
REQ-009 The block SHALL have port fu_ready, output, N_FU bits: per-FU result accept.
REQ-010 The block SHALL have port fu_tag, input, N_FU*BITWIDTH bits: per-FU producing RS entry ID, with FU i in slice i.
REQ-011 The block SHALL have port fu_data, input, N_FU*BITWIDTH bits: per-FU result value, with FU i in slice i.
REQ-012 The block SHALL have port cdb_valid, output, 1 bit: the broadcast is valid this cycle.
REQ-013 The block SHALL have port cdb_tag, output, BITWIDTH bits: the broadcast tag, compared by every RS against its operand tags.
REQ-014 The block SHALL have port cdb_data, output, BITWIDTH bits: the broadcast result value.
REQ-015 The block SHALL have port cdb_src, output, clog2(N_FU) bits: the index of the FU that produced the broadcast.
REQ-016 The block SHALL have port busy, output, 1 bit: a result is buffered or being broadcast.

Function
REQ-017 The block SHALL hold one FIFO per FU, FIFO_DEPTH entries deep, each entry being {tag, data}, with a count register of clog2(FIFO_DEPTH)+1 bits and wrapping read/write pointers.
REQ-018 fu_ready[i] SHALL equal en AND NOT full[i] AND NOT flush, derived only from registered state, with no combinational path from fu_valid.
REQ-019 A push into FIFO i SHALL occur on an edge where fu_valid[i] and fu_ready[i] are both 1; fu_tag and fu_data SHALL be sampled on that same edge.
REQ-020 Each cycle with en=1 and flush=0, the block SHALL make the round-robin grant over the non-empty FIFOs using the registered pointer rr_ptr: first the non-empty index at or above rr_ptr, wrapping to 0.
REQ-021 The head entry of the granted FIFO SHALL be popped and registered onto cdb_tag, cdb_data and cdb_src on the same edge, with cdb_valid=1 for that one cycle.
REQ-022 After a grant to FIFO i, rr_ptr SHALL become (i+1) mod N_FU; with no grant, rr_ptr SHALL hold.
REQ-023 If no FIFO is non-empty, cdb_valid SHALL be 0 after the edge, and cdb_tag, cdb_data and cdb_src SHALL hold their previous values.
REQ-024 Latency SHALL be as follows: an entry pushed into an empty FIFO on edge k is eligible for the grant in the cycle after k; at the earliest it is broadcast on edge k+1, with cdb_valid high during the cycle after edge k+1.
REQ-025 The CDB SHALL have no backpressure, and each entry SHALL be broadcast exactly once.
REQ-026 Per-FU order SHALL be preserved; ordering across FUs is set only by the round-robin grant.
REQ-027 Push and pop on the same FIFO in the same cycle SHALL both take effect, leaving count unchanged; a push while full is impossible by REQ-018.
REQ-028 Pointer and count arithmetic SHALL wrap modulo FIFO_DEPTH for the pointers and saturate within 0..FIFO_DEPTH for count, never overflowing.
REQ-029 With en=0, the block SHALL NOT push or pop, SHALL hold rr_ptr and FIFO contents, and SHALL drive cdb_valid=0 after the next edge.
REQ-030 flush=1 SHALL have priority over push and pop: all counts and pointers go to 0, rr_ptr goes to 0, cdb_valid=0 after the edge, and a result offered in that cycle is dropped (fu_ready=0).
REQ-031 busy SHALL equal (OR of all non-empty[i]) OR cdb_valid.

Reset
REQ-032 rst_n=0 SHALL, asynchronously, clear all FIFO counts and pointers and set rr_ptr=0, cdb_valid=0, cdb_tag=0, cdb_data=0 and cdb_src=0.
REQ-033 Reset SHALL force fu_ready=0 and busy=0 while rst_n=0.
REQ-034 Reset asserted mid-operation SHALL discard all buffered results with no partial broadcast.
REQ-035 FIFO data storage need not be reset.
REQ-036 After release, operation SHALL begin on the first rising edge with rst_n=1.

Verification
REQ-037 Single result: FU2 offers tag=0x00010003, data=0xDEADBEEF at edge k -> cdb_valid=1 with cdb_tag=0x00010003, cdb_data=0xDEADBEEF and cdb_src=2 in the cycle after k+1 only.
REQ-038 Contention: all 4 FUs push in the same cycle with rr_ptr=0 -> broadcasts on 4 consecutive cycles in order src 0,1,2,3 -> rr_ptr=0 afterwards.
REQ-039 Fairness: FU0 pushes continuously and FU1 pushes once -> FU1 is broadcast within 2 grants, and FU0 entries appear in push order.
REQ-040 Full: FU3 pushes 2 entries while grants go to other FUs -> fu_ready[3]=0 until FU3 is popped -> it returns to 1 the cycle after the pop.
REQ-041 Flush or enable: flush with 3 buffered entries -> no further cdb_valid and busy=0 after 1 cycle; en=0 with 1 buffered entry -> no broadcast until en=1.
REQ-042 Reset: rst_n dropped mid-burst -> immediately cdb_valid=0 and fu_ready=0 -> after release, no stale entry is ever broadcast.
